aes128_inv_round_unit: RTL and testbench

//  Iterative AES-128 inverse linear round for the decrypt path: InvShiftRows -> AddRoundKey -> InvMixColumns.

---
 rtl/aes128_inv_round_unit_if.sv | 31 +++
 rtl/aes128_inv_round_unit.sv | 199 +++++++++++++++++++
 tb/tb_aes128_inv_round_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_inv_round_unit_if.sv
// Block-level handshake bundle for the AES-128 inverse linear round unit.
// AES128_INV_ROUND_ABORT_EN adds the abort_i control line.
interface aes128_inv_round_unit_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic         skip_mix_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] data_o;
`ifdef AES128_INV_ROUND_ABORT_EN
    logic         abort_i;
`endif

    modport master (
        output in_valid_i, data_i, key_i, skip_mix_i, out_ready_i,
`ifdef AES128_INV_ROUND_ABORT_EN
        output abort_i,
`endif
        input  in_ready_o, out_valid_o, data_o
    );

    modport slave (
        input  in_valid_i, data_i, key_i, skip_mix_i, out_ready_i,
`ifdef AES128_INV_ROUND_ABORT_EN
        input  abort_i,
`endif
        output in_ready_o, out_valid_o, data_o
    );
endinterface

// File: rtl/aes128_inv_round_unit.sv
// Iterative AES-128 inverse linear round: InvShiftRows -> AddRoundKey -> InvMixColumns.
// Optional feature: define AES128_INV_ROUND_ABORT_EN to add a synchronous abort_i that drops the block.
module aes128_inv_round_unit #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes128_inv_round_unit_if.slave bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multipliers 09/0b/0d/0e built from the x2/x4/x8 chain.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h09:   r = x8 ^ b;
            8'h0b:   r = x8 ^ x2 ^ b;
            8'h0d:   r = x8 ^ x4 ^ b;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        s0 = c[7:0];
        s1 = c[15:8];
        s2 = c[23:16];
        s3 = c[31:24];
        return {gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e),
                gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
                gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
                gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09)};
    endfunction

    // Row r of output column c comes from input column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
        logic [127:0] r;
        logic [1:0]   src;
        r = 128'd0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                src = 2'(col - row);
                r[(col * 4 + row) * 8 +: 8] = d[{src, 2'(row), 3'd0} +: 8];
            end
        end
        return r;
    endfunction

    state_e       state_r;
    state_e       state_next_s;
    logic [1:0]   col_r;
    logic [1:0]   col_next_s;
    logic [127:0] st_r;
    logic [127:0] st_next_s;
    logic [127:0] key_r;
    logic [127:0] key_next_s;
    logic         skip_r;
    logic         skip_next_s;
    logic [127:0] dout_r;
    logic [127:0] dout_next_s;
    logic         out_valid_r;
    logic         out_valid_next_s;
    logic         in_ready_r;
    logic         in_ready_next_s;
    logic [31:0]  mix_in_s  [COLS_PER_CYCLE];
    logic [31:0]  mix_out_s [COLS_PER_CYCLE];

    // Shared column datapath: key add then optional InvMixColumns on the current column group.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            mix_in_s[k]  = st_r[{col_r + 2'(k), 5'd0} +: 32] ^ key_r[{col_r + 2'(k), 5'd0} +: 32];
            mix_out_s[k] = skip_r ? mix_in_s[k] : inv_mix_col(mix_in_s[k]);
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next_s     = state_r;
        col_next_s       = col_r;
        st_next_s        = st_r;
        key_next_s       = key_r;
        skip_next_s      = skip_r;
        dout_next_s      = dout_r;
        out_valid_next_s = out_valid_r;
        in_ready_next_s  = in_ready_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid_i && in_ready_r) begin
                    state_next_s    = CALC;
                    st_next_s       = inv_shift_rows(bus.data_i);
                    key_next_s      = bus.key_i;
                    skip_next_s     = bus.skip_mix_i;
                    col_next_s      = 2'd0;
                    in_ready_next_s = 1'b0;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            CALC: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    st_next_s[{col_r + 2'(k), 5'd0} +: 32] = mix_out_s[k];
                end
                if (col_r == LAST_COL) begin
                    state_next_s     = DONE;
                    col_next_s       = 2'd0;
                    dout_next_s      = st_next_s;
                    out_valid_next_s = 1'b1;
                end else begin
                    col_next_s       = col_r + COL_STEP;
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_next_s     = IDLE;
                    out_valid_next_s = 1'b0;
                    in_ready_next_s  = 1'b1;
                end else begin
                    state_next_s     = DONE;
                end
            end
            default: begin
                state_next_s     = IDLE;
                col_next_s       = 2'd0;
                out_valid_next_s = 1'b0;
                in_ready_next_s  = 1'b1;
            end
        endcase
`ifdef AES128_INV_ROUND_ABORT_EN
        // Abort overrides any handshake decoded above.
        if (bus.abort_i) begin
            state_next_s     = IDLE;
            col_next_s       = 2'd0;
            st_next_s        = 128'd0;
            dout_next_s      = 128'd0;
            out_valid_next_s = 1'b0;
            in_ready_next_s  = 1'b1;
        end else begin
            state_next_s     = state_next_s;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            col_r       <= 2'd0;
            st_r        <= 128'd0;
            key_r       <= 128'd0;
            skip_r      <= 1'b0;
            dout_r      <= 128'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            col_r       <= col_next_s;
            st_r        <= st_next_s;
            key_r       <= key_next_s;
            skip_r      <= skip_next_s;
            dout_r      <= dout_next_s;
            out_valid_r <= out_valid_next_s;
            in_ready_r  <= in_ready_next_s;
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.data_o      = dout_r;

endmodule

// File: tb/tb_aes128_inv_round_unit.sv
// Directed bench for aes128_inv_round_unit: three instances (1/2/4 columns per cycle) share one stimulus.
module tb_aes128_inv_round_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes128_inv_round_unit_if if1 ();
    aes128_inv_round_unit_if if2 ();
    aes128_inv_round_unit_if if4 ();

    aes128_inv_round_unit #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    aes128_inv_round_unit #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    aes128_inv_round_unit #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    assign if2.in_valid_i  = if1.in_valid_i;
    assign if2.data_i      = if1.data_i;
    assign if2.key_i       = if1.key_i;
    assign if2.skip_mix_i  = if1.skip_mix_i;
    assign if2.out_ready_i = if1.out_ready_i;
    assign if4.in_valid_i  = if1.in_valid_i;
    assign if4.data_i      = if1.data_i;
    assign if4.key_i       = if1.key_i;
    assign if4.skip_mix_i  = if1.skip_mix_i;
    assign if4.out_ready_i = if1.out_ready_i;
`ifdef AES128_INV_ROUND_ABORT_EN
    assign if2.abort_i = if1.abort_i;
    assign if4.abort_i = if1.abort_i;
`endif

    localparam logic [127:0] T1_DATA = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] T1_EXP  = 128'h0306090c_0f020508_0b0e0104_070a0d00;
    localparam logic [127:0] T3_EXP  = 128'hfcf9f6f3_f0fdfaf7_f4f1fefb_f8f5f2ff;
    localparam logic [127:0] T2_DATA = {4{32'hbca14d8e}};
    localparam logic [127:0] T2_EXP  = {4{32'h455313db}};
    localparam logic [127:0] K1_DATA = {4{32'hbda04c8f}};
    localparam logic [127:0] C0_DATA = 128'h00004d00_00a10000_bc000000_0000008e;
    localparam logic [127:0] C0_EXP  = {96'd0, 32'h455313db};
    localparam logic [127:0] ONES    = {128{1'b1}};

    int tests_run    = 0;
    int tests_failed = 0;
    int lat1;
    int lat2;
    int lat4;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  128'(if1.in_ready_o),  128'd1);
        check({tag, "_out_valid"}, 128'(if1.out_valid_o), 128'd0);
        check({tag, "_data_o"},    if1.data_o,            128'd0);
    endtask

    // Accept one block, then record the edge count at which each instance first shows out_valid_o.
    task automatic run_block(input logic [127:0] d, input logic [127:0] k, input logic s);
        @(negedge clk);
        check("ready_before_accept", 128'(if1.in_ready_o), 128'd1);
        if1.in_valid_i = 1'b1;
        if1.data_i     = d;
        if1.key_i      = k;
        if1.skip_mix_i = s;
        @(posedge clk);
        #1;
        if1.in_valid_i = 1'b0;
        if1.data_i     = ~d;
        if1.key_i      = ~k;
        if1.skip_mix_i = ~s;
        check("ready_low_after_accept", 128'(if1.in_ready_o), 128'd0);
        lat1 = 99;
        lat2 = 99;
        lat4 = 99;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (if1.out_valid_o && lat1 == 99) lat1 = e;
            if (if2.out_valid_o && lat2 == 99) lat2 = e;
            if (if4.out_valid_o && lat4 == 99) lat4 = e;
        end
    endtask

    task automatic check_block(input string tag, input logic [127:0] exp);
        check({tag, "_lat1"},  128'(lat1), 128'd4);
        check({tag, "_lat2"},  128'(lat2), 128'd2);
        check({tag, "_lat4"},  128'(lat4), 128'd1);
        check({tag, "_data1"}, if1.data_o, exp);
        check({tag, "_data2"}, if2.data_o, exp);
        check({tag, "_data4"}, if4.data_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        if1.in_valid_i  = 1'b0;
        if1.data_i      = 128'd0;
        if1.key_i       = 128'd0;
        if1.skip_mix_i  = 1'b0;
        if1.out_ready_i = 1'b1;
`ifdef AES128_INV_ROUND_ABORT_EN
        if1.abort_i     = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_block(T1_DATA, 128'd0, 1'b1);
        check_block("t1_shift_only", T1_EXP);
        run_block(T2_DATA, 128'd0, 1'b0);
        check_block("t2_mix", T2_EXP);
        run_block(T1_DATA, ONES, 1'b1);
        check_block("t3_key_ff", T3_EXP);
        run_block(K1_DATA, {16{8'h01}}, 1'b0);
        check_block("key_then_mix", T2_EXP);
        run_block(C0_DATA, 128'd0, 1'b0);
        check_block("shift_then_mix_col0", C0_EXP);

        // Backpressure: result held while in_valid_i stays high with a different block.
        @(negedge clk);
        if1.out_ready_i = 1'b0;
        if1.in_valid_i  = 1'b1;
        if1.data_i      = T1_DATA;
        if1.key_i       = 128'd0;
        if1.skip_mix_i  = 1'b1;
        @(posedge clk);
        #1;
        if1.data_i     = T2_DATA;
        if1.skip_mix_i = 1'b0;
        lat1 = 99;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (if1.out_valid_o && lat1 == 99) lat1 = e;
            if (lat1 != 99) break;
        end
        check("t5_lat1", 128'(lat1), 128'd4);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("t5_hold_data", if1.data_o, T1_EXP);
            check("t5_hold_valid", 128'(if1.out_valid_o), 128'd1);
            check("t5_no_accept", 128'(if1.in_ready_o), 128'd0);
        end
        @(negedge clk);
        if1.out_ready_i = 1'b1;
        if1.in_valid_i  = 1'b0;
        @(posedge clk);
        #1;
        check("t5_valid_drop", 128'(if1.out_valid_o), 128'd0);
        check("t5_back_idle", 128'(if1.in_ready_o), 128'd1);
        @(posedge clk);
        #1;
        check("t5_still_idle", 128'(if1.in_ready_o), 128'd1);
        check("t5_data_retained", if1.data_o, T1_EXP);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        if1.in_valid_i = 1'b1;
        if1.data_i     = T2_DATA;
        if1.key_i      = 128'd0;
        if1.skip_mix_i = 1'b0;
        @(posedge clk);
        #1;
        if1.in_valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_block(T2_DATA, 128'd0, 1'b0);
        check_block("t6_after_reset", T2_EXP);

`ifdef AES128_INV_ROUND_ABORT_EN
        // Abort mid-CALC, then abort racing an input handshake in IDLE.
        @(negedge clk);
        if1.in_valid_i = 1'b1;
        if1.data_i     = T1_DATA;
        if1.skip_mix_i = 1'b1;
        @(posedge clk);
        #1;
        if1.in_valid_i = 1'b0;
        @(negedge clk);
        if1.abort_i = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_abort_calc");
        if1.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        check("abort_blocks_accept", 128'(if1.in_ready_o), 128'd1);
        @(negedge clk);
        if1.abort_i    = 1'b0;
        if1.in_valid_i = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
        end
        #1;
        check("abort_no_result", 128'(if1.out_valid_o), 128'd0);
        run_block(T2_DATA, 128'd0, 1'b0);
        check_block("t6_after_abort", T2_EXP);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
